bit_serial_add_ctrl: RTL and testbench
======================================

BIT_SERIAL_ADD_CTRL -- requirements
Module: bit_serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start_valid  input  1  requester presents operands.
REQ-005 Port: start_ready  output  1  controller can accept operands.
REQ-006 Port: op_a  input  WIDTH  operand A; sampled only on accept.
REQ-007 Port: op_b  input  WIDTH  operand B; sampled only on accept.
REQ-008 Port: res_valid  output  1  result and carry-out are valid.
REQ-009 Port: res_ready  input  1  consumer takes the result.
REQ-010 Port: result  output  WIDTH  sum (or difference), bit-serially computed.
REQ-011 Port: cout  output  1  final carry out of the MSB.
REQ-012 Port: busy  output  1  high in RUN or DONE.

Function
REQ-013 The block SHALL sequence one 1-bit full-adder cell over WIDTH cycles, LSB first, to form op_a + op_b.
REQ-014 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE: start_ready=1; on start_valid=1, load op_a/op_b into shift registers, clear bit counter, set carry to 0, go to RUN.
REQ-016 RUN: each cycle, add the LSBs of both shift registers and the carry; shift the sum bit into the result register MSB; shift both operand registers right; update carry; increment counter.
REQ-017 RUN SHALL last exactly WIDTH cycles. After the WIDTH-th bit, go to DONE.
REQ-018 Latency: accept at edge k -> res_valid high after edge k+WIDTH.
REQ-019 DONE: res_valid=1; result and cout SHALL hold stable until res_valid and res_ready are both high on a rising edge, then go to IDLE.
REQ-020 A new operand pair is accepted no earlier than the cycle after the result handshake; back-to-back throughput is one op per WIDTH+2 cycles.
REQ-021 start_valid in RUN or DONE SHALL be ignored; operands SHALL NOT be latched and state SHALL NOT be disturbed.
REQ-022 res_ready in IDLE or RUN SHALL have no effect.
REQ-023 Counter width SHALL be $clog2(WIDTH+1). The counter SHALL NOT wrap within an operation.
REQ-024 Arithmetic is modulo 2^WIDTH; the overflow carry appears only on cout.
REQ-025 start_ready, res_valid and busy SHALL be decoded from registered state only (no combinational input-to-output path).

Reset
REQ-026 Asserting rst at any time, including mid-RUN or in DONE, SHALL immediately force state=IDLE. Any in-flight operation is discarded.
REQ-027 Values during reset: start_ready=1, res_valid=0, busy=0, result=0, cout=0, counter=0, carry=0, operand registers=0.
REQ-028 First accept is possible on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro SERIAL_ADD_SUB_EN. When defined, add port sub (input, 1, sampled on accept) and an internal sub flag register.
REQ-030 With SERIAL_ADD_SUB_EN defined and sub=1: B bits SHALL be inverted into the cell, initial carry=1, result=op_a-op_b mod 2^WIDTH, and cout=1 means no borrow.
REQ-031 Without SERIAL_ADD_SUB_EN: no sub port, add-only, identical timing.

Structure
REQ-032 Package serial_add_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and default WIDTH constant.
REQ-033 Sub-module serial_fa_cell (inputs a, b, cin; outputs s, co) SHALL be a purely combinational full adder built from two half-adder stages plus an OR; it is instantiated once.

Verification (WIDTH=8)
REQ-034 Accept op_a=0x00, op_b=0x00 -> res_valid after 8 cycles, result=0x00, cout=0.
REQ-035 Accept 0xFF+0x01 -> result=0x00, cout=1. Accept 0x5A+0x25 -> result=0x7F, cout=0.
REQ-036 Hold res_ready=0 for 5 cycles in DONE -> result/cout stable, start_ready=0; result handshake then returns to IDLE, start_ready=1 one cycle later.
REQ-037 Change op_a/op_b and pulse start_valid during RUN -> final result reflects originally accepted operands.
REQ-038 Assert rst at RUN cycle 4 -> next cycle state IDLE, res_valid=0, result=0; a subsequent 0x10+0x20 yields 0x30.
REQ-039 With SERIAL_ADD_SUB_EN: 0x05-0x07 -> result=0xFE, cout=0; 0x07-0x05 -> 0x02, cout=1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the default operand width and the three-state FSM encoding.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // FSM encoding kept as plain constants so older code can compare against them directly
    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder used as the single arithmetic cell of the serial adder.
// Built from two half-adder stages whose carries are merged with an OR.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic ha1_sum;
    logic ha1_carry;
    logic ha2_carry;

    // First half adder combines the operand bits, second folds in the carry
    always_comb begin
        ha1_sum   = a ^ b;
        ha1_carry = a & b;
        s         = ha1_sum ^ cin;
        ha2_carry = ha1_sum & cin;
        co        = ha1_carry | ha2_carry;
    end

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial add controller: accepts an operand pair, walks a single
// full-adder cell over WIDTH cycles LSB first, then holds the result
// until the consumer takes it.
// Optional feature macro: SERIAL_ADD_SUB_EN adds a 'sub' input that turns
// the operation into op_a - op_b (cout=1 meaning no borrow).
module bit_serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             cell_b;
    logic             cell_s;
    logic             cell_co;
    logic             init_carry;

`ifdef SERIAL_ADD_SUB_EN
    logic             sub_q;

    // Remember the operation type for the whole run; it is only sampled on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (state == IDLE && start_valid) begin
            sub_q <= sub;
        end
    end

    // Subtraction feeds inverted B bits and starts with carry=1 (two's complement)
    always_comb begin
        cell_b     = b_sh[0] ^ sub_q;
        init_carry = sub;
    end
`else
    // Add-only build: B goes straight into the cell and the run starts with no carry
    always_comb begin
        cell_b     = b_sh[0];
        init_carry = 1'b0;
    end
`endif

    serial_fa_cell u_cell (
        .a   (a_sh[0]),
        .b   (cell_b),
        .cin (carry),
        .s   (cell_s),
        .co  (cell_co)
    );

    // FSM and datapath: load on accept, one sum bit per RUN cycle, hold in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sh  <= op_a;
                        b_sh  <= op_b;
                        cnt   <= '0;
                        carry <= init_carry;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res_sh <= {cell_s, res_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= cell_co;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status flags come purely from the registered state
    always_comb begin
        start_ready = (state == IDLE);
        res_valid   = (state == DONE);
        busy        = (state != IDLE);
        result      = res_sh;
        cout        = carry;
    end

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Self-checking bench for bit_serial_add_ctrl (WIDTH=8).
// Stimulus pushes expected sums into a scoreboard queue; a monitor on the
// falling edge compares whatever the DUT presents while res_valid is high.
// Define SERIAL_ADD_SUB_EN to also exercise the subtract mode.
module tb_bit_serial_add_ctrl;

    localparam int W     = 8;
    localparam int BOUND = 4 * W + 10;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        int           acc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         busy;

    exp_t sb_q[$];
    int   checks;
    int   errors;
    int   cyc;
    int   ready_mode;
    logic seen_valid;
    logic expect_idle;

    bit_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
`ifdef SERIAL_ADD_SUB_EN
        .sub         (sub),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .cout        (cout),
        .busy        (busy)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter used to measure accept-to-valid latency
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: random backpressure, forced low (hold) or forced high (drain)
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       res_ready = ($urandom_range(0, 2) != 0);
                1:       res_ready = 1'b0;
                default: res_ready = 1'b1;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every falling edge with a result presented, compare it to the head of the queue
    always @(negedge clk) begin
        if (rst) begin
            seen_valid  = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (expect_idle) begin
                checkOutput("idle_start_ready", 32'(start_ready), 32'd1);
                checkOutput("idle_res_valid", 32'(res_valid), 32'd0);
                expect_idle = 1'b0;
            end
            if (res_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: got 0x%0h with empty scoreboard (t=%0t)", result, $time);
                end else begin
                    if (!seen_valid) begin
                        checkOutput("latency", 32'(cyc - sb_q[0].acc), 32'(W));
                    end
                    seen_valid = 1'b1;
                    checkOutput("result", 32'(result), 32'(sb_q[0].res));
                    checkOutput("cout", 32'(cout), 32'(sb_q[0].co));
                    checkOutput("done_start_ready", 32'(start_ready), 32'd0);
                    checkOutput("done_busy", 32'(busy), 32'd1);
                    if (res_ready) begin
                        void'(sb_q.pop_front());
                        seen_valid  = 1'b0;
                        expect_idle = 1'b1;
                    end
                end
            end
        end
    end

    // Issue one operation: wait for ready, drive it, predict, then wiggle inputs during RUN
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int   waited;
        exp_t e;
        int   full;
        waited = 0;
        while (!start_ready && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        if (!start_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: start_ready still 0 after %0d cycles", waited);
            return;
        end
        op_a        = a;
        op_b        = b;
        sub         = s;
        start_valid = 1'b1;
        if (s) begin
            e.res = a - b;
            e.co  = (a >= b);
        end else begin
            full  = int'(a) + int'(b);
            e.res = full[W-1:0];
            e.co  = (full >= (1 << W));
        end
        e.acc = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        for (int i = 0; i < W / 2; i++) begin
            op_a        = W'($urandom);
            op_b        = W'($urandom);
            sub         = 1'($urandom);
            start_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start_valid = 1'b0;
    endtask

    task automatic drainQueue();
        int waited;
        waited = 0;
        while (sb_q.size() != 0 && waited < 8 * BOUND) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d results still pending, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_result"}, 32'(result), 32'd0);
        checkOutput({tag, "_cout"}, 32'(cout), 32'd0);
    endtask

    // Main sequence: reset, directed corners, hold, mid-run reset, random mix
    initial begin
        int waited;
        checks      = 0;
        errors      = 0;
        ready_mode  = 0;
        rst         = 1'b1;
        start_valid = 1'b0;
        op_a        = '0;
        op_b        = '0;
        sub         = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;

        applyStimulus(8'h00, 8'h00, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0);
        applyStimulus(8'h5A, 8'h25, 1'b0);
        drainQueue();

        // Consumer stalls for five cycles in DONE, then takes the result
        ready_mode = 1;
        applyStimulus(8'h3C, 8'h4B, 1'b0);
        waited = 0;
        while (!res_valid && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("hold_reached_done", 32'(res_valid), 32'd1);
        repeat (5) @(negedge clk);
        ready_mode = 2;
        drainQueue();
        ready_mode = 0;

        // Reset in the middle of RUN discards the operation
        while (!start_ready) @(negedge clk);
        op_a        = 8'hC3;
        op_b        = 8'h5A;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb_q.delete();
        checkResetValues("midrun_reset");
        rst = 1'b0;
        applyStimulus(8'h10, 8'h20, 1'b0);
        drainQueue();

        for (int i = 0; i < 25; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'b0);
        end

`ifdef SERIAL_ADD_SUB_EN
        applyStimulus(8'h05, 8'h07, 1'b1);
        applyStimulus(8'h07, 8'h05, 1'b1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
        end
`endif

        ready_mode = 2;
        drainQueue();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
